// File: rtl/video_timing_pkg.sv
// Shared types, NTSC arcade defaults and window helpers for the video timing slice.
`timescale 1ns/1ps
package video_timing_pkg;

  typedef enum logic {
    SYNC_ACTIVE_LOW  = 1'b0,
    SYNC_ACTIVE_HIGH = 1'b1
  } sync_pol_t;

  localparam int unsigned ACC_W_DEF         = 16;
  localparam int unsigned INC_7M16          = 4692;
  localparam int unsigned H_W_DEF           = 9;
  localparam int unsigned V_W_DEF           = 9;
  localparam int unsigned H_TOTAL_NTSC      = 455;
  localparam int unsigned V_TOTAL_NTSC      = 262;
  localparam int unsigned HBLANK_START_NTSC = 256;
  localparam int unsigned HSYNC_START_NTSC  = 288;
  localparam int unsigned HSYNC_END_NTSC    = 320;
  localparam int unsigned VBLANK_START_NTSC = 224;
  localparam int unsigned VSYNC_START_NTSC  = 234;
  localparam int unsigned VSYNC_END_NTSC    = 237;

  // Half-open window test; an empty window (lo >= hi) is never active.
  function automatic logic in_window(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Map an active/inactive sync state onto the pin level for the chosen polarity.
  function automatic logic sync_level(input logic active, input sync_pol_t pol);
    return (pol == SYNC_ACTIVE_HIGH) ? active : ~active;
  endfunction

endpackage

// File: rtl/phase_accum_ce.sv
// Fractional phase accumulator producing a one-cycle tick on each carry out.
`timescale 1ns/1ps
module phase_accum_ce #(
  parameter int unsigned ACC_W = 16,
  parameter int unsigned INC   = 4692
) (
  input  logic clk100,
  input  logic rst_b,
  input  logic run,
  output logic ce
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0] r_acc;
  logic [SUM_W-1:0] w_sum;

  assign w_sum = {1'b0, r_acc} + SUM_W'(INC);

  // Tick is the carry of the upcoming add; the consumer registers it.
  assign ce = run & w_sum[ACC_W];

  // Phase advances only while running, so a pause loses no phase.
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      r_acc <= '0;
    end else if (run) begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator: pixel enable, H/V counters, sync/blank windows and strobes.
`timescale 1ns/1ps
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned ACC_W        = ACC_W_DEF,
  parameter int unsigned INC          = INC_7M16,
  parameter int unsigned H_W          = H_W_DEF,
  parameter int unsigned V_W          = V_W_DEF,
  parameter int unsigned H_TOTAL      = H_TOTAL_NTSC,
  parameter int unsigned V_TOTAL      = V_TOTAL_NTSC,
  parameter int unsigned HBLANK_START = HBLANK_START_NTSC,
  parameter int unsigned HSYNC_START  = HSYNC_START_NTSC,
  parameter int unsigned HSYNC_END    = HSYNC_END_NTSC,
  parameter int unsigned VBLANK_START = VBLANK_START_NTSC,
  parameter int unsigned VSYNC_START  = VSYNC_START_NTSC,
  parameter int unsigned VSYNC_END    = VSYNC_END_NTSC,
  parameter sync_pol_t   SYNC_POL     = SYNC_ACTIVE_LOW
) (
  input  logic           clk100,
  input  logic           rst_b,
  input  logic           run,
  output logic           pix_ce,
  output logic [H_W-1:0] hcount,
  output logic [V_W-1:0] vcount,
  output logic           hsync,
  output logic           vsync,
  output logic           hblank,
  output logic           vblank,
  output logic           line_start,
  output logic           frame_start
);

  localparam logic HBLANK_RST = (HBLANK_START == 0);
  localparam logic VBLANK_RST = (VBLANK_START == 0);

  logic           w_tick;
  logic           w_h_last;
  logic           w_v_last;
  logic [H_W-1:0] w_hcount_nxt;
  logic [V_W-1:0] w_vcount_nxt;

  logic           r_pix_ce;
  logic [H_W-1:0] r_hcount;
  logic [V_W-1:0] r_vcount;
  logic           r_hsync;
  logic           r_vsync;
  logic           r_hblank;
  logic           r_vblank;
  logic           r_line_start;
  logic           r_frame_start;

  phase_accum_ce #(
    .ACC_W (ACC_W),
    .INC   (INC)
  ) u_phase_accum_ce (
    .clk100 (clk100),
    .rst_b  (rst_b),
    .run    (run),
    .ce     (w_tick)
  );

  // Next counter values; they hold unless a pixel tick is due this cycle.
  always_comb begin
    w_h_last     = (r_hcount == H_W'(H_TOTAL - 1));
    w_v_last     = (r_vcount == V_W'(V_TOTAL - 1));
    w_hcount_nxt = r_hcount;
    w_vcount_nxt = r_vcount;
    if (w_tick) begin
      w_hcount_nxt = w_h_last ? '0 : r_hcount + H_W'(1);
      if (w_h_last) begin
        w_vcount_nxt = w_v_last ? '0 : r_vcount + V_W'(1);
      end
    end
  end

  // Counters, windows and strobes share one edge so they are coherent with pix_ce.
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      r_pix_ce      <= 1'b0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hblank      <= HBLANK_RST;
      r_vblank      <= VBLANK_RST;
      r_hsync       <= sync_level(in_window(0, HSYNC_START, HSYNC_END), SYNC_POL);
      r_vsync       <= sync_level(in_window(0, VSYNC_START, VSYNC_END), SYNC_POL);
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pix_ce      <= w_tick;
      r_hcount      <= w_hcount_nxt;
      r_vcount      <= w_vcount_nxt;
      r_hblank      <= (32'(w_hcount_nxt) >= HBLANK_START);
      r_vblank      <= (32'(w_vcount_nxt) >= VBLANK_START);
      r_hsync       <= sync_level(in_window(32'(w_hcount_nxt), HSYNC_START, HSYNC_END),
                                  SYNC_POL);
      r_vsync       <= sync_level(in_window(32'(w_vcount_nxt), VSYNC_START, VSYNC_END),
                                  SYNC_POL);
      r_line_start  <= w_tick & w_h_last;
      r_frame_start <= w_tick & w_h_last & w_v_last;
    end
  end

  assign pix_ce      = r_pix_ce;
  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: small-mode, NTSC-rate and degenerate instances.
`timescale 1ns/1ps
module tb_video_timing_gen;
  import video_timing_pkg::*;

  // Small mode exercised with random run, freeze and mid-frame reset.
  localparam int A_INC = 16384;
  localparam int A_HT  = 8;
  localparam int A_VT  = 4;
  localparam int A_HBS = 6;
  localparam int A_HSS = 6;
  localparam int A_HSE = 7;
  localparam int A_VBS = 3;
  localparam int A_VSS = 0;
  localparam int A_VSE = 1;

  typedef struct {
    int stamp;
    int h;
    int v;
    bit hb;
    bit vb;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
  } exp_t;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  always @(posedge clk100) edge_cnt <= edge_cnt + 1;

  logic       rst_n_a, run_a, pix_ce_a, hsync_a, vsync_a, hblank_a, vblank_a, ls_a, fs_a;
  logic [8:0] hcount_a, vcount_a;
  logic       rst_n_b, run_b, pix_ce_b, hsync_b, vsync_b, hblank_b, vblank_b, ls_b, fs_b;
  logic [8:0] hcount_b, vcount_b;
  logic       rst_n_c, run_c, pix_ce_c, hsync_c, vsync_c, hblank_c, vblank_c, ls_c, fs_c;
  logic [8:0] hcount_c, vcount_c;
  logic       rst_n_d, run_d, pix_ce_d, hsync_d, vsync_d, hblank_d, vblank_d, ls_d, fs_d;
  logic [8:0] hcount_d, vcount_d;

  video_timing_gen #(
    .INC(A_INC), .H_TOTAL(A_HT), .V_TOTAL(A_VT), .HBLANK_START(A_HBS),
    .HSYNC_START(A_HSS), .HSYNC_END(A_HSE), .VBLANK_START(A_VBS),
    .VSYNC_START(A_VSS), .VSYNC_END(A_VSE), .SYNC_POL(SYNC_ACTIVE_LOW)
  ) u_a (
    .clk100(clk100), .rst_b(rst_n_a), .run(run_a), .pix_ce(pix_ce_a),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .hblank(hblank_a), .vblank(vblank_a), .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen u_b (
    .clk100(clk100), .rst_b(rst_n_b), .run(run_b), .pix_ce(pix_ce_b),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .hblank(hblank_b), .vblank(vblank_b), .line_start(ls_b), .frame_start(fs_b)
  );

  video_timing_gen #(.INC(0)) u_c (
    .clk100(clk100), .rst_b(rst_n_c), .run(run_c), .pix_ce(pix_ce_c),
    .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
    .hblank(hblank_c), .vblank(vblank_c), .line_start(ls_c), .frame_start(fs_c)
  );

  video_timing_gen #(
    .INC(16384), .H_TOTAL(8), .V_TOTAL(4), .HBLANK_START(8),
    .HSYNC_START(3), .HSYNC_END(3), .VBLANK_START(5),
    .VSYNC_START(3), .VSYNC_END(1), .SYNC_POL(SYNC_ACTIVE_HIGH)
  ) u_d (
    .clk100(clk100), .rst_b(rst_n_d), .run(run_d), .pix_ce(pix_ce_d),
    .hcount(hcount_d), .vcount(vcount_d), .hsync(hsync_d), .vsync(vsync_d),
    .hblank(hblank_d), .vblank(vblank_d), .line_start(ls_d), .frame_start(fs_d)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: state after p pixel ticks, derived from plain pixel-count arithmetic.
  function automatic exp_t mdl(input longint p, input bit tick, input int ht, input int vt,
                               input int hbs, input int hss, input int hse, input int vbs,
                               input int vss, input int vse, input bit pol_high);
    exp_t e;
    bit   ha, va;
    e.stamp = 0;
    e.h  = int'(p % ht);
    e.v  = int'((p / ht) % vt);
    e.hb = (e.h >= hbs);
    e.vb = (e.v >= vbs);
    ha   = (e.h >= hss) && (e.h < hse);
    va   = (e.v >= vss) && (e.v < vse);
    e.hs = pol_high ? ha : !ha;
    e.vs = pol_high ? va : !va;
    e.ls = tick && (e.h == 0);
    e.fs = tick && (e.h == 0) && (e.v == 0);
    return e;
  endfunction

  function automatic exp_t mdl_a(input longint p, input bit tick);
    return mdl(p, tick, A_HT, A_VT, A_HBS, A_HSS, A_HSE, A_VBS, A_VSS, A_VSE, 1'b0);
  endfunction

  function automatic exp_t mdl_b(input longint p);
    return mdl(p, 1'b0, int'(H_TOTAL_NTSC), int'(V_TOTAL_NTSC), int'(HBLANK_START_NTSC),
               int'(HSYNC_START_NTSC), int'(HSYNC_END_NTSC), int'(VBLANK_START_NTSC),
               int'(VSYNC_START_NTSC), int'(VSYNC_END_NTSC), 1'b0);
  endfunction

  // Instance A scoreboard state.
  exp_t   q_a[$];
  exp_t   last_a;
  longint n_a = 0;
  longint p_a = 0;
  int     pulses_a = 0;

  // Drive run for the next edge, advance the phase model, queue any expected tick.
  task automatic step_a(input bit r);
    longint np;
    exp_t   e;
    run_a = r;
    if (r) begin
      n_a++;
      np = (n_a * A_INC) / 65536;
      if (np != p_a) begin
        p_a = np;
        e = mdl_a(p_a, 1'b1);
        e.stamp = edge_cnt + 1;
        q_a.push_back(e);
      end
    end
    @(negedge clk100);
  endtask

  // Monitor for A: pops on every pix_ce, otherwise checks that state holds.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk100);
      #1;
      if (!rst_n_a) begin
        last_a = mdl_a(0, 1'b0);
        chk("a_ce_in_reset", int'(pix_ce_a), 0);
        continue;
      end
      if (pix_ce_a) begin
        pulses_a++;
        if (q_a.size() == 0) begin
          chk("a_unexpected_pix_ce", 1, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_ce_cycle", edge_cnt, e.stamp);
          chk("a_hcount", int'(hcount_a), e.h);
          chk("a_vcount", int'(vcount_a), e.v);
          chk("a_hblank", int'(hblank_a), int'(e.hb));
          chk("a_vblank", int'(vblank_a), int'(e.vb));
          chk("a_hsync", int'(hsync_a), int'(e.hs));
          chk("a_vsync", int'(vsync_a), int'(e.vs));
          chk("a_line_start", int'(ls_a), int'(e.ls));
          chk("a_frame_start", int'(fs_a), int'(e.fs));
          last_a = e;
        end
      end else begin
        chk("a_hold_hcount", int'(hcount_a), last_a.h);
        chk("a_hold_vcount", int'(vcount_a), last_a.v);
        chk("a_hold_hblank", int'(hblank_a), int'(last_a.hb));
        chk("a_hold_vblank", int'(vblank_a), int'(last_a.vb));
        chk("a_hold_hsync", int'(hsync_a), int'(last_a.hs));
        chk("a_hold_vsync", int'(vsync_a), int'(last_a.vs));
        chk("a_idle_line_start", int'(ls_a), 0);
        chk("a_idle_frame_start", int'(fs_a), 0);
      end
    end
  end

  int   cnt_b = 0, prev_b = 0, first_b = 0, badgap_b = 0;
  int   cnt_c = 0, cnt_d = 0, viol_d = 0;
  bit   found;
  exp_t eb;
  exp_t er;
  int   p0;

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0; rst_n_d = 1'b0;
    run_a = 1'b0; run_b = 1'b1; run_c = 1'b1; run_d = 1'b1;
    repeat (3) @(negedge clk100);
    eb = mdl_b(0);
    chk("b_rst_hcount", int'(hcount_b), eb.h);
    chk("b_rst_hsync", int'(hsync_b), int'(eb.hs));
    chk("b_rst_vsync", int'(vsync_b), int'(eb.vs));
    chk("d_rst_hsync", int'(hsync_d), 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1; rst_n_d = 1'b1;
    fork
      begin : seq_a
        // Continuous run: 250 pulses in the first 1000 cycles.
        p0 = pulses_a;
        for (int i = 0; i < 1000; i++) step_a(1'b1);
        chk("a_rate_1000", pulses_a - p0, 1000 * A_INC / 65536);
        for (int i = 0; i < 1500; i++) step_a($urandom_range(0, 3) != 0);
        // Freeze mid-line at hcount 3.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
          if (mdl_a(p_a, 1'b0).h == 3) found = 1'b1;
          else step_a(1'b1);
        end
        chk("a_reach_h3", int'(found), 1);
        p0 = pulses_a;
        for (int i = 0; i < 50; i++) step_a(1'b0);
        chk("a_freeze_pulses", pulses_a - p0, 0);
        chk("a_freeze_hcount", int'(hcount_a), mdl_a(p_a, 1'b0).h);
        for (int i = 0; i < 800; i++) step_a($urandom_range(0, 3) != 0);
        // Asynchronous reset at hcount 5, vcount 2.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
          er = mdl_a(p_a, 1'b0);
          if (er.h == 5 && er.v == 2) found = 1'b1;
          else step_a(1'b1);
        end
        chk("a_reach_h5v2", int'(found), 1);
        chk("a_queue_before_reset", q_a.size(), 0);
        q_a.delete();
        rst_n_a = 1'b0;
        #1;
        er = mdl_a(0, 1'b0);
        chk("a_rst_pix_ce", int'(pix_ce_a), 0);
        chk("a_rst_hcount", int'(hcount_a), er.h);
        chk("a_rst_vcount", int'(vcount_a), er.v);
        chk("a_rst_hblank", int'(hblank_a), int'(er.hb));
        chk("a_rst_vblank", int'(vblank_a), int'(er.vb));
        chk("a_rst_hsync", int'(hsync_a), int'(er.hs));
        chk("a_rst_vsync", int'(vsync_a), int'(er.vs));
        chk("a_rst_line_start", int'(ls_a), 0);
        chk("a_rst_frame_start", int'(fs_a), 0);
        @(negedge clk100);
        @(negedge clk100);
        n_a = 0;
        p_a = 0;
        rst_n_a = 1'b1;
        for (int i = 0; i < 300; i++) step_a(1'b1);
        for (int i = 0; i < 300; i++) step_a($urandom_range(0, 1) != 0);
        for (int i = 0; i < 4; i++) step_a(1'b0);
        chk("a_queue_drained", q_a.size(), 0);
      end
      begin : seq_b
        for (int i = 1; i <= 65536; i++) begin
          @(posedge clk100);
          #1;
          if (pix_ce_b) begin
            cnt_b++;
            if (prev_b == 0) first_b = i;
            else if ((i - prev_b) != 13 && (i - prev_b) != 14) badgap_b++;
            prev_b = i;
          end
        end
        chk("b_first_ce_cycle", first_b, (65536 + int'(INC_7M16) - 1) / int'(INC_7M16));
        chk("b_pulses_65536", cnt_b, int'(INC_7M16));
        chk("b_gap_violations", badgap_b, 0);
        eb = mdl_b(longint'(INC_7M16));
        chk("b_end_hcount", int'(hcount_b), eb.h);
        chk("b_end_vcount", int'(vcount_b), eb.v);
        chk("b_end_hblank", int'(hblank_b), int'(eb.hb));
        chk("b_end_hsync", int'(hsync_b), int'(eb.hs));
        chk("b_end_vblank", int'(vblank_b), int'(eb.vb));
        chk("b_end_vsync", int'(vsync_b), int'(eb.vs));
      end
      begin : seq_cd
        for (int i = 1; i <= 10000; i++) begin
          @(posedge clk100);
          #1;
          if (pix_ce_c) cnt_c++;
          if (pix_ce_d) cnt_d++;
          if (hsync_d || vsync_d || hblank_d || vblank_d) viol_d++;
        end
        chk("c_inc0_pulses", cnt_c, 0);
        chk("c_inc0_hcount", int'(hcount_c), 0);
        chk("d_pulses", cnt_d, 10000 * 16384 / 65536);
        chk("d_empty_window_viol", viol_d, 0);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
